// File: rtl/stack_pkg.sv
// Shared definitions for the stack-pointer controller: command indices,
// error flag positions and the command conflict check.
package stack_pkg;

    localparam int unsigned NUM_CMDS  = 5;
    localparam int unsigned CMD_LD    = 0;
    localparam int unsigned CMD_INC   = 1;
    localparam int unsigned CMD_DEC   = 2;
    localparam int unsigned CMD_ENTER = 3;
    localparam int unsigned CMD_LEAVE = 4;

    localparam int unsigned NUM_ERRS = 4;
    localparam int unsigned ERR_HI   = 0;
    localparam int unsigned ERR_LO   = 1;
    localparam int unsigned ERR_RNG  = 2;
    localparam int unsigned ERR_CMD  = 3;

    // True when more than one command bit is set (clearing the lowest set bit leaves something).
    function automatic logic cmd_conflict(input logic [NUM_CMDS-1:0] cmds);
        return (cmds & (cmds - NUM_CMDS'(1))) != '0;
    endfunction

endpackage

// File: rtl/stack_bound_chk.sv
// Combinational legality checks for inc, dec and ld against the SP bounds,
// evaluated one bit wider than the pointer so no sum can wrap.
module stack_bound_chk #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] sp,
    input  logic [WIDTH-1:0] din,
    input  logic [WIDTH-1:0] step,
    input  logic [WIDTH-1:0] limit_lo,
    input  logic [WIDTH-1:0] limit_hi,
    output logic             inc_ok,
    output logic             dec_ok,
    output logic             ld_ok
);

    localparam int unsigned EXT_W = WIDTH + 1;

    logic [EXT_W-1:0] sp_x;
    logic [EXT_W-1:0] step_x;
    logic [EXT_W-1:0] lo_x;
    logic [EXT_W-1:0] hi_x;

    assign sp_x   = EXT_W'(sp);
    assign step_x = EXT_W'(step);
    assign lo_x   = EXT_W'(limit_lo);
    assign hi_x   = EXT_W'(limit_hi);

    assign inc_ok = (sp_x + step_x) <= hi_x;
    assign dec_ok = sp_x >= (lo_x + step_x);
    assign ld_ok  = (din >= limit_lo) && (din <= limit_hi);

endmodule

// File: rtl/stack_ptr_ctl.sv
// Stack/frame pointer controller: bounded SP moves, FP save/restore,
// sticky error flags and tri-state bus drivers for SP and FP.
module stack_ptr_ctl
    import stack_pkg::*;
#(
    parameter int unsigned       WIDTH     = 32,
    parameter logic [WIDTH-1:0]  RESET_VAL = 'h3FF,
    parameter logic [WIDTH-1:0]  STEP      = 1,
    parameter logic [WIDTH-1:0]  LIMIT_LO  = 0,
    parameter logic [WIDTH-1:0]  LIMIT_HI  = 'h3FF
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [WIDTH-1:0] Din,
    input  logic             ld,
    input  logic             inc,
    input  logic             dec,
    input  logic             enter,
    input  logic             leave,
    input  logic             oe,
    input  logic             fp_oe,
    input  logic             clr_err,
    output logic [WIDTH-1:0] Dout,
    output logic [WIDTH-1:0] FpOut,
    output logic [WIDTH-1:0] sp_q,
    output logic             hi_err,
    output logic             lo_err,
    output logic             rng_err,
    output logic             cmd_err
);

    logic [WIDTH-1:0]    sp_d;
    logic [WIDTH-1:0]    fp_q;
    logic [WIDTH-1:0]    fp_d;
    logic [NUM_ERRS-1:0] err_q;
    logic [NUM_ERRS-1:0] err_d;
    logic [NUM_ERRS-1:0] err_new;
    logic [NUM_CMDS-1:0] cmd_vec;
    logic                inc_ok;
    logic                dec_ok;
    logic                ld_ok;

    stack_bound_chk #(
        .WIDTH (WIDTH)
    ) u_bound_chk (
        .sp       (sp_q),
        .din      (Din),
        .step     (STEP),
        .limit_lo (LIMIT_LO),
        .limit_hi (LIMIT_HI),
        .inc_ok   (inc_ok),
        .dec_ok   (dec_ok),
        .ld_ok    (ld_ok)
    );

    // Command decode and next-state; a refused command leaves SP/FP untouched.
    always_comb begin
        cmd_vec            = '0;
        cmd_vec[CMD_LD]    = ld;
        cmd_vec[CMD_INC]   = inc;
        cmd_vec[CMD_DEC]   = dec;
        cmd_vec[CMD_ENTER] = enter;
        cmd_vec[CMD_LEAVE] = leave;
        sp_d               = sp_q;
        fp_d               = fp_q;
        err_new            = '0;

        if (cmd_conflict(cmd_vec)) begin
            err_new[ERR_CMD] = 1'b1;
        end else if (cmd_vec[CMD_LD]) begin
            if (ld_ok) sp_d = Din;
            else       err_new[ERR_RNG] = 1'b1;
        end else if (cmd_vec[CMD_INC]) begin
            if (inc_ok) sp_d = sp_q + STEP;
            else        err_new[ERR_HI] = 1'b1;
        end else if (cmd_vec[CMD_DEC]) begin
            if (dec_ok) sp_d = sp_q - STEP;
            else        err_new[ERR_LO] = 1'b1;
        end else if (cmd_vec[CMD_ENTER]) begin
            fp_d = sp_q;
        end else if (cmd_vec[CMD_LEAVE]) begin
            sp_d = fp_q;
        end

        // A clear wipes old flags but never hides an error raised in the same cycle.
        err_d = clr_err ? err_new : (err_q | err_new);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            sp_q  <= RESET_VAL;
            fp_q  <= RESET_VAL;
            err_q <= '0;
        end else begin
            sp_q  <= sp_d;
            fp_q  <= fp_d;
            err_q <= err_d;
        end
    end

    assign hi_err  = err_q[ERR_HI];
    assign lo_err  = err_q[ERR_LO];
    assign rng_err = err_q[ERR_RNG];
    assign cmd_err = err_q[ERR_CMD];

    assign Dout  = oe    ? sp_q : {WIDTH{1'bz}};
    assign FpOut = fp_oe ? fp_q : {WIDTH{1'bz}};

endmodule

// File: tb/tb_stack_ptr_ctl.sv
// Bench for stack_ptr_ctl: a default instance and a STEP=4/LIMIT_LO='h100
// instance share stimulus and are checked against a behavioural model.
module tb_stack_ptr_ctl;

    localparam int unsigned W = 32;

    logic         Clk = 1'b0;
    logic         Reset, ld, inc, dec, enter, leave, oe, fp_oe, clr_err;
    logic [W-1:0] Din;

    wire  [W-1:0] dout_a, fpout_a, dout_b, fpout_b;
    logic [W-1:0] sp_a, sp_b;
    logic         hi_a, lo_a, rng_a, cmd_a, hi_b, lo_b, rng_b, cmd_b;
    logic [3:0]   flg_a, flg_b;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state per instance; flags packed as {cmd, rng, lo, hi}.
    longint unsigned m_sp[2], m_fp[2];
    logic [3:0]      m_err[2];
    longint unsigned p_step[2] = '{1, 4};
    longint unsigned p_lo[2]   = '{0, 'h100};
    longint unsigned p_hi[2]   = '{'h3FF, 'h3FF};
    longint unsigned p_rv      = 'h3FF;

    always #5 Clk = ~Clk;

    assign flg_a = {cmd_a, rng_a, lo_a, hi_a};
    assign flg_b = {cmd_b, rng_b, lo_b, hi_b};

    stack_ptr_ctl u_dut_a (
        .Clk (Clk), .Reset (Reset), .Din (Din),
        .ld (ld), .inc (inc), .dec (dec), .enter (enter), .leave (leave),
        .oe (oe), .fp_oe (fp_oe), .clr_err (clr_err),
        .Dout (dout_a), .FpOut (fpout_a), .sp_q (sp_a),
        .hi_err (hi_a), .lo_err (lo_a), .rng_err (rng_a), .cmd_err (cmd_a)
    );

    stack_ptr_ctl #(
        .WIDTH (W), .RESET_VAL ('h3FF), .STEP (4), .LIMIT_LO ('h100), .LIMIT_HI ('h3FF)
    ) u_dut_b (
        .Clk (Clk), .Reset (Reset), .Din (Din),
        .ld (ld), .inc (inc), .dec (dec), .enter (enter), .leave (leave),
        .oe (oe), .fp_oe (fp_oe), .clr_err (clr_err),
        .Dout (dout_b), .FpOut (fpout_b), .sp_q (sp_b),
        .hi_err (hi_b), .lo_err (lo_b), .rng_err (rng_b), .cmd_err (cmd_b)
    );

    // Behavioural update from the command rules, applied at each rising edge.
    task model_step();
        int         n;
        logic [3:0] e;
        n = int'(ld) + int'(inc) + int'(dec) + int'(enter) + int'(leave);
        for (int k = 0; k < 2; k++) begin
            e = 4'b0000;
            if (Reset) begin
                m_sp[k] = p_rv; m_fp[k] = p_rv; m_err[k] = 4'b0000;
            end else begin
                if (n > 1) e[3] = 1'b1;
                else if (ld) begin
                    if (longint'(Din) >= p_lo[k] && longint'(Din) <= p_hi[k]) m_sp[k] = longint'(Din);
                    else e[2] = 1'b1;
                end else if (inc) begin
                    if (m_sp[k] + p_step[k] <= p_hi[k]) m_sp[k] = m_sp[k] + p_step[k];
                    else e[0] = 1'b1;
                end else if (dec) begin
                    if (m_sp[k] >= p_lo[k] + p_step[k]) m_sp[k] = m_sp[k] - p_step[k];
                    else e[1] = 1'b1;
                end else if (enter) m_fp[k] = m_sp[k];
                else if (leave) m_sp[k] = m_fp[k];
                m_err[k] = clr_err ? e : (m_err[k] | e);
            end
        end
    endtask

    task tick();
        @(posedge Clk);
        model_step();
        #1;
    endtask

    task idle();
        Reset = 1'b0; ld = 1'b0; inc = 1'b0; dec = 1'b0;
        enter = 1'b0; leave = 1'b0; clr_err = 1'b0;
    endtask

    task test_reset();
        idle(); oe = 1'b0; fp_oe = 1'b0; Din = '0;
        Reset = 1'b1; inc = 1'b1; clr_err = 1'b1;
        tick();
        idle(); oe = 1'b1; fp_oe = 1'b1;
        #1;
        n_checks++;
        if ({sp_a, sp_b, dout_a, dout_b} !== {32'h3FF, 32'h3FF, 32'h3FF, 32'h3FF}) begin
            n_fail++;
            $display("FAIL reset_sp: sp a/b %h/%h dout a/b %h/%h expected all 3ff", sp_a, sp_b, dout_a, dout_b);
        end
        n_checks++;
        if ({fpout_a, fpout_b} !== {32'h3FF, 32'h3FF}) begin
            n_fail++;
            $display("FAIL reset_fp: fpout a/b %h/%h expected 3ff/3ff", fpout_a, fpout_b);
        end
        n_checks++;
        if ({flg_a, flg_b} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_flags: a/b %b/%b expected 0000/0000", flg_a, flg_b);
        end
        oe = 1'b0; fp_oe = 1'b0;
        #1;
        // A released bus must no longer show SP; sp_q stays driven.
        n_checks++;
        if (dout_a === 32'h3FF || dout_b === 32'h3FF || fpout_a === 32'h3FF || sp_a !== 32'h3FF) begin
            n_fail++;
            $display("FAIL bus_release: dout a/b %h/%h fpout_a %h sp_a %h expected released bus, sp 3ff",
                     dout_a, dout_b, fpout_a, sp_a);
        end
    endtask

    task test_lo_bound();
        logic [W-1:0] exp_a[3] = '{32'h107, 32'h106, 32'h105};
        logic [W-1:0] exp_b[3] = '{32'h104, 32'h100, 32'h100};
        idle(); ld = 1'b1; Din = 32'h108; tick();
        idle(); dec = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if ({sp_a, sp_b} !== {exp_a[i], exp_b[i]}) begin
                n_fail++;
                $display("FAIL lo_dec%0d: sp a/b %h/%h expected %h/%h", i, sp_a, sp_b, exp_a[i], exp_b[i]);
            end
        end
        n_checks++;
        if ({flg_a, flg_b} !== 8'b0000_0010) begin
            n_fail++;
            $display("FAIL lo_err_set: flags a/b %b/%b expected 0000/0010", flg_a, flg_b);
        end
        idle(); clr_err = 1'b1; tick();
        n_checks++;
        if ({flg_a, flg_b, sp_b} !== {8'h00, 32'h100}) begin
            n_fail++;
            $display("FAIL lo_err_clr: flags a/b %b/%b sp_b %h expected 0000/0000 100", flg_a, flg_b, sp_b);
        end
    endtask

    task test_hi_bound();
        idle(); ld = 1'b1; Din = 32'h3FF; tick();
        idle(); inc = 1'b1; tick();
        n_checks++;
        if ({sp_a, sp_b, flg_a, flg_b} !== {32'h3FF, 32'h3FF, 8'b0001_0001}) begin
            n_fail++;
            $display("FAIL hi_bound: sp a/b %h/%h flags %b/%b expected 3ff/3ff 0001/0001", sp_a, sp_b, flg_a, flg_b);
        end
        idle(); ld = 1'b1; Din = 32'h400; tick();
        n_checks++;
        if ({sp_a, sp_b, flg_a, flg_b} !== {32'h3FF, 32'h3FF, 8'b0101_0101}) begin
            n_fail++;
            $display("FAIL ld_range: sp a/b %h/%h flags %b/%b expected 3ff/3ff 0101/0101", sp_a, sp_b, flg_a, flg_b);
        end
        idle(); clr_err = 1'b1; tick();
    endtask

    task test_frame();
        idle(); ld = 1'b1; Din = 32'h200; tick();
        idle(); enter = 1'b1; tick();
        idle(); dec = 1'b1;
        repeat (5) tick();
        n_checks++;
        if ({sp_a, sp_b} !== {32'h1FB, 32'h1EC}) begin
            n_fail++;
            $display("FAIL frame_dec: sp a/b %h/%h expected 1fb/1ec", sp_a, sp_b);
        end
        idle(); leave = 1'b1; tick();
        idle(); fp_oe = 1'b1; oe = 1'b1; #1;
        n_checks++;
        if ({sp_a, sp_b, fpout_a, fpout_b, dout_b} !== {32'h200, 32'h200, 32'h200, 32'h200, 32'h200}) begin
            n_fail++;
            $display("FAIL frame_leave: sp %h/%h fpout %h/%h dout_b %h expected all 200",
                     sp_a, sp_b, fpout_a, fpout_b, dout_b);
        end
        idle(); ld = 1'b1; leave = 1'b1; Din = 32'h250; tick();
        n_checks++;
        if ({sp_a, sp_b, flg_a, flg_b} !== {32'h200, 32'h200, 8'b1000_1000}) begin
            n_fail++;
            $display("FAIL cmd_conflict: sp %h/%h flags %b/%b expected 200/200 1000/1000", sp_a, sp_b, flg_a, flg_b);
        end
        idle(); clr_err = 1'b1; inc = 1'b1; tick();
        idle(); enter = 1'b1; tick();
        idle(); leave = 1'b1; tick();
        n_checks++;
        if ({sp_a, sp_b, fpout_a, fpout_b} !== {32'h201, 32'h204, 32'h201, 32'h204}) begin
            n_fail++;
            $display("FAIL enter_leave: sp %h/%h fpout %h/%h expected 201/204 201/204", sp_a, sp_b, fpout_a, fpout_b);
        end
        oe = 1'b0; fp_oe = 1'b0;
    endtask

    task test_back_to_back();
        idle(); ld = 1'b1; Din = 32'h200; tick();
        idle(); inc = 1'b1; tick();
        n_checks++;
        if ({sp_a, sp_b} !== {32'h201, 32'h204}) begin
            n_fail++;
            $display("FAIL b2b_inc: sp a/b %h/%h expected 201/204", sp_a, sp_b);
        end
        idle(); dec = 1'b1; tick();
        n_checks++;
        if ({sp_a, sp_b} !== {32'h200, 32'h200}) begin
            n_fail++;
            $display("FAIL b2b_dec: sp a/b %h/%h expected 200/200", sp_a, sp_b);
        end
    endtask

    task test_reset_override();
        idle(); ld = 1'b1; Din = 32'h3FF; tick();
        idle(); inc = 1'b1; tick();
        idle(); Reset = 1'b1; inc = 1'b1; tick();
        n_checks++;
        if ({sp_a, sp_b, flg_a, flg_b} !== {32'h3FF, 32'h3FF, 8'h00}) begin
            n_fail++;
            $display("FAIL reset_override: sp %h/%h flags %b/%b expected 3ff/3ff 0000/0000", sp_a, sp_b, flg_a, flg_b);
        end
        idle(); ld = 1'b1; Din = 32'h100; tick();
        Din = 32'h500; tick();
        Din = 32'h000; tick();
        idle(); dec = 1'b1; clr_err = 1'b1; tick();
        n_checks++;
        if ({sp_a, sp_b, flg_a, flg_b} !== {32'h000, 32'h100, 8'b0010_0010}) begin
            n_fail++;
            $display("FAIL clr_with_new_err: sp %h/%h flags %b/%b expected 000/100 0010/0010", sp_a, sp_b, flg_a, flg_b);
        end
    endtask

    task test_random();
        logic [W-1:0] o_sp[2], o_dout[2], o_fp[2];
        logic [3:0]   o_err[2];
        for (int c = 0; c < 400; c++) begin
            Reset   = ($urandom_range(0, 39) == 0);
            ld      = ($urandom_range(0, 4) == 0);
            inc     = ($urandom_range(0, 3) == 0);
            dec     = ($urandom_range(0, 3) == 0);
            enter   = ($urandom_range(0, 5) == 0);
            leave   = ($urandom_range(0, 5) == 0);
            clr_err = ($urandom_range(0, 9) == 0);
            oe      = 1'($urandom_range(0, 1));
            fp_oe   = 1'($urandom_range(0, 1));
            Din     = W'($urandom_range(0, 'h4FF));
            tick();
            o_sp   = '{sp_a, sp_b};
            o_err  = '{flg_a, flg_b};
            o_dout = '{dout_a, dout_b};
            o_fp   = '{fpout_a, fpout_b};
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if ({o_sp[k], o_err[k]} !== {W'(m_sp[k]), m_err[k]}) begin
                    n_fail++;
                    $display("FAIL rand_state[%0d] cyc %0d: sp %h flags %b expected sp %h flags %b",
                             k, c, o_sp[k], o_err[k], W'(m_sp[k]), m_err[k]);
                end
                n_checks++;
                if ((oe && o_dout[k] !== W'(m_sp[k])) || (fp_oe && o_fp[k] !== W'(m_fp[k]))) begin
                    n_fail++;
                    $display("FAIL rand_bus[%0d] cyc %0d: dout %h fpout %h expected %h/%h (oe %b fp_oe %b)",
                             k, c, o_dout[k], o_fp[k], W'(m_sp[k]), W'(m_fp[k]), oe, fp_oe);
                end
            end
        end
    endtask

    initial begin
        idle(); oe = 1'b0; fp_oe = 1'b0; Din = '0;
        Reset = 1'b1;
        test_reset();
        test_lo_bound();
        test_hi_bound();
        test_frame();
        test_back_to_back();
        test_reset_override();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/stack_ptr_ctl.md
# stack_ptr_ctl

Parametrised stack-pointer controller for the Bus Interface Unit. It is the next generation of the 32-bit stack register. It keeps a stack pointer (SP) and a frame pointer (FP), moves SP by a configurable step, and saves/restores SP via FP for call frames. Every SP change is checked against programmable lower and upper bounds, and violations are reported through sticky error flags. SP and FP drive the shared internal bus through tri-state outputs.

## Interface
- WIDTH, 32: pointer width in bits.
- RESET_VAL, 'h3FF: SP and FP value after reset.
- STEP, 1: SP increment/decrement amount; must be at least 1.
- LIMIT_LO, 0: lowest legal SP, unsigned.
- LIMIT_HI, 'h3FF: highest legal SP, unsigned; requires LIMIT_LO ≤ RESET_VAL ≤ LIMIT_HI.
- Clk  in  1  clock; single clock domain; all state changes on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- Din  in  WIDTH  load value for ld.
- ld  in  1  SP ← Din.
- inc  in  1  SP ← SP + STEP.
- dec  in  1  SP ← SP − STEP.
- enter  in  1  FP ← SP.
- leave  in  1  SP ← FP.
- oe  in  1  drive SP onto Dout.
- fp_oe  in  1  drive FP onto FpOut.
- clr_err  in  1  clear all sticky error flags.
- Dout  out  WIDTH  SP when oe = 1, else high-Z.
- FpOut  out  WIDTH  FP when fp_oe = 1, else high-Z.
- sp_q  out  WIDTH  SP, always driven, for debug and bounds logic.
- hi_err  out  1  sticky: an inc was refused at the upper bound.
- lo_err  out  1  sticky: a dec was refused at the lower bound.
- rng_err  out  1  sticky: an ld value was out of range.
- cmd_err  out  1  sticky: more than one command was asserted in the same cycle.

## Operation
- Commands: {ld, inc, dec, enter, leave}. At most one may be asserted per cycle.
  - Zero asserted: hold.
  - Two or more asserted: SP and FP hold, and cmd_err sets.
- inc:
  - Legal if SP + STEP ≤ LIMIT_HI. Compute the sum in WIDTH+1 bits so it cannot wrap.
  - Otherwise SP holds and hi_err sets.
- dec:
  - Legal if SP ≥ LIMIT_LO + STEP. Compare in WIDTH+1 bits.
  - Otherwise SP holds and lo_err sets.
- ld:
  - Legal if LIMIT_LO ≤ Din ≤ LIMIT_HI.
  - Otherwise SP holds and rng_err sets.
- enter: FP ← SP. SP is unchanged and no bound check is needed.
- leave: SP ← FP. FP is only ever loaded from SP, so it is always in range and no check is made.
- SP never wraps under any input sequence.
- Error flags:
  - A flag stays set until Reset or clr_err.
  - If clr_err and a new error occur in the same cycle, the new error's flag ends at 1 and all other flags clear.
- oe and fp_oe are combinational. They are independent of each other and of the commands.

## Timing
- Reset, sampled at the rising edge:
  - SP = FP = RESET_VAL.
  - All error flags = 0.
  - Reset overrides every command and clr_err in that cycle.
  - sp_q = RESET_VAL from the edge on which Reset is sampled.
  - Dout/FpOut remain governed only by oe/fp_oe.
- Latency:
  - A command sampled at edge N changes SP/FP, visible on sp_q/Dout, after edge N.
  - Error flags assert after the same edge N.
- Back-to-back commands are legal every cycle.
  - Example: inc at N then dec at N+1 returns SP to its original value after N+1.
- enter and leave in consecutive cycles: leave uses the FP written by enter, so SP is unchanged.
- Dout/FpOut go high-Z or driven combinationally within the same cycle that oe/fp_oe change.

## Structure
- Package stack_pkg:
  - Command index localparams: CMD_LD, CMD_INC, CMD_DEC, CMD_ENTER, CMD_LEAVE.
  - A one-hot check function.
  - Error flag bit positions for any future packed status word.
- Sub-module stack_bound_chk, combinational:
  - Inputs: SP, Din, STEP, LIMIT_LO, LIMIT_HI, all WIDTH+1-bit safe.
  - Outputs: inc_ok, dec_ok, ld_ok.
  - Unit-testable on its own.
- Top level: SP/FP registers, command decode, sticky-flag logic, tri-state drivers.

## Test plan
- Reset, then oe = 1 with default parameters → Dout = 'h3FF, sp_q = 'h3FF, all flags 0; oe = 0 → Dout = Z.
- STEP = 4, LIMIT_LO = 'h100, ld 'h108, then dec ×3 → SP goes 'h104, 'h100, then holds at 'h100 with lo_err = 1 after the third dec; clr_err → lo_err = 0.
- inc at SP = 'h3FF (LIMIT_HI = 'h3FF) → SP stays 'h3FF, hi_err = 1. ld 'h400 → SP unchanged, rng_err = 1.
- ld 'h200, enter, dec ×5, leave, fp_oe = 1 → SP = 'h200 and FpOut = 'h200; ld 'h250 with leave in the same cycle → SP holds 'h200, cmd_err = 1.
- Reset asserted while inc is also asserted with hi_err set → after the edge SP = 'h3FF and all flags 0; clr_err in the same cycle as a new dec underflow → lo_err = 1.
